// File: rtl/rv_mem_responder.sv
// Single-port memory responder for the core fetch/load/store port: RV32I byte/half/word accesses.
// Latency: rsp_valid rises LATENCY cycles after the accept edge (1 = the cycle right after the accept edge).
// Backpressure: one transaction in flight; req_ready only in IDLE; the response is held stable until rsp_ready.
module rv_mem_responder #(
  parameter int XLEN     = 32,
  parameter int MEM_SIZE = 1024,
  parameter int LATENCY  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int              AW        = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int              NB        = XLEN / 8;
  localparam logic [XLEN-1:0] WORDS     = XLEN'(MEM_SIZE);
  localparam logic [3:0]      WAIT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [XLEN-1:0] pend_rdata;
  logic            pend_err;

  // Every word powers up as a NOP so unwritten fetch addresses execute harmlessly.
  logic [XLEN-1:0] mem [MEM_SIZE] = '{default: XLEN'(32'h0000_0013)};

  logic            accept;
  logic [1:0]      lane;
  logic [XLEN-1:0] word_idx;
  logic [AW-1:0]   widx;
  logic [XLEN-1:0] rd_word;
  logic            acc_err;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] load_val;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wr_lanes;
  logic [XLEN-1:0] wr_word;
  logic [XLEN-1:0] nxt_rdata;

  assign accept   = req_valid && req_ready;
  assign lane     = req_addr[1:0];
  assign word_idx = {2'b00, req_addr[XLEN-1:2]};
  assign widx     = req_addr[AW+1:2];
  assign rd_word  = mem[widx];

  // Decode the request: error check, load extraction/extension and store byte merge.
  always_comb begin
    acc_err = 1'b0;
    case (req_size)
      2'd0:    acc_err = 1'b0;
      2'd1:    acc_err = lane[0];
      2'd2:    acc_err = (lane != 2'd0);
      default: acc_err = 1'b1;
    endcase
    // Indices past the end never alias back into the array.
    if (word_idx >= WORDS) acc_err = 1'b1;

    byte_v = rd_word[{lane, 3'b000} +: 8];
    half_v = rd_word[{lane[1], 4'b0000} +: 16];
    case (req_size)
      2'd0:    load_val = req_unsigned ? {{(XLEN-8){1'b0}}, byte_v}
                                       : {{(XLEN-8){byte_v[7]}}, byte_v};
      2'd1:    load_val = req_unsigned ? {{(XLEN-16){1'b0}}, half_v}
                                       : {{(XLEN-16){half_v[15]}}, half_v};
      default: load_val = rd_word;
    endcase

    be = '0;
    case (req_size)
      2'd0: be[lane] = 1'b1;
      2'd1: begin
        be[{lane[1], 1'b0}] = 1'b1;
        be[{lane[1], 1'b1}] = 1'b1;
      end
      default: be = '1;
    endcase

    // Replicate right-aligned store data across every lane; byte enables pick the live ones.
    case (req_size)
      2'd0:    wr_lanes = {NB{req_wdata[7:0]}};
      2'd1:    wr_lanes = {(NB/2){req_wdata[15:0]}};
      default: wr_lanes = req_wdata;
    endcase
    for (int i = 0; i < NB; i++) begin
      wr_word[8*i +: 8] = be[i] ? wr_lanes[8*i +: 8] : rd_word[8*i +: 8];
    end

    nxt_rdata = (acc_err || req_we) ? '0 : load_val;
  end

  // Stores commit at the accept edge, so a later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (!rst && accept && req_we && !acc_err) mem[widx] <= wr_word;
  end

  // Transaction FSM: capture the result at accept, count out the latency, hold until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      cnt        <= 4'd0;
      pend_rdata <= '0;
      pend_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready  <= 1'b0;
            pend_rdata <= nxt_rdata;
            pend_err   <= acc_err;
            if (LATENCY > 1) begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= nxt_rdata;
              rsp_err   <= acc_err;
            end
          end
        end
        WAIT: begin
          if (cnt <= 4'd1) begin
            state     <= RESP;
            cnt       <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pend_rdata;
            rsp_err   <= pend_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_responder.sv
// Directed plus randomized transactions against a byte-level memory model.
// Latency: measured per transaction against LAT.
// Backpressure: rsp_ready held low for a chosen number of cycles per transaction.
module tb_rv_mem_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] m_mem [1024];
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic [31:0] last_rdata;
  logic        last_err;

  rv_mem_responder #(.XLEN(32), .MEM_SIZE(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin passes++; end
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Memory as a flat byte space: an access of 2**size bytes, little endian.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns);
    int          n;
    logic [31:0] a;
    logic [31:0] v;
    n = 1 << size;
    exp_err   = (size == 2'd3) || ((addr % n) != 0) || ((addr >> 2) >= 1024);
    exp_rdata = '0;
    v = '0;
    if (exp_err) return;
    for (int b = 0; b < n; b++) begin
      a = addr + b;
      if (we) m_mem[a >> 2][8*(a % 4) +: 8] = wdata[8*b +: 8];
      else    v[8*b +: 8] = m_mem[a >> 2][8*(a % 4) +: 8];
    end
    if (!we) begin
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      exp_rdata = v;
    end
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input bit keep);
    int w;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", req_ready, 1);
    @(posedge clk);
    model(we, addr, wdata, size, uns);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic complete(input int bp, input bit early);
    int lat;
    bit got;
    got = 0;
    lat = 0;
    if (early && bp == 0) rsp_ready = 1'b1;
    for (int k = 1; k <= LAT + 3 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        lat = k;
      end else begin
        chk("busy_req_ready", req_ready, 0);
      end
    end
    chk("latency", lat, LAT);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_err", rsp_err, exp_err);
    last_rdata = rsp_rdata;
    last_err   = rsp_err;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, exp_rdata);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    logic        r_we;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    int          r_sel;

    for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0000_0013;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    rst = 1'b0;

    // Word store then load.
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 0); complete(0, 0);
    chk("store_err", last_err, 0);
    issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0); complete(0, 0);
    chk("word_load", last_rdata, 32'hDEAD_BEEF);

    // Byte and half lanes.
    issue(1'b1, 32'h11, 32'hAAAA_AA55, 2'd0, 1'b0, 0); complete(1, 0);
    issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0); complete(0, 0);
    chk("byte_merge", last_rdata, 32'hDEAD_55EF);
    issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0); complete(0, 0);
    chk("lb_signed", last_rdata, 32'hFFFF_FFDE);
    issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0); complete(0, 0);
    chk("lbu", last_rdata, 32'h0000_00DE);
    issue(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 0); complete(0, 0);
    chk("lh_signed", last_rdata, 32'hFFFF_DEAD);

    // Error cases.
    issue(1'b0, 32'h12, 32'h0, 2'd2, 1'b0, 0); complete(0, 0);
    chk("misaligned_word_err", last_err, 1);
    chk("misaligned_word_rdata", last_rdata, 0);
    issue(1'b1, 32'h11, 32'h0000_1234, 2'd1, 1'b0, 0); complete(0, 0);
    chk("misaligned_half_err", last_err, 1);
    issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0); complete(0, 0);
    chk("mem_unchanged", last_rdata, 32'hDEAD_55EF);
    issue(1'b0, 32'h1000, 32'h0, 2'd2, 1'b0, 0); complete(0, 0);
    chk("out_of_range_err", last_err, 1);
    issue(1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 0); complete(0, 0);
    chk("reserved_size_err", last_err, 1);

    // Backpressure with a held request: the second request waits for the handshake.
    issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1);
    req_addr = 32'h40; req_size = 2'd2; req_we = 1'b0;
    complete(5, 0);
    @(posedge clk);
    model(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
    #1 req_valid = 1'b0;
    complete(0, 0);
    chk("nop_fetch", last_rdata, 32'h0000_0013);

    // Reset while waiting keeps the store but drops the response.
    issue(1'b1, 32'h20, 32'h1234_5678, 2'd2, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_req_ready", req_ready, 1);
    issue(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0); complete(0, 0);
    chk("store_survives_reset", last_rdata, 32'h1234_5678);

    // Randomized traffic concentrated on a few words and the top-of-memory boundary.
    for (int t = 0; t < 60; t++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_sel  = $urandom_range(0, 9);
      if (r_sel == 0)      r_addr = $urandom;
      else if (r_sel == 1) r_addr = 32'((1022 + $urandom_range(0, 3)) * 4 + $urandom_range(0, 3));
      else                 r_addr = 32'($urandom_range(0, 63));
      issue(r_we, r_addr, $urandom, r_size, r_uns, 0);
      complete($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
